fft_frame_reader: RTL and testbench

FFT_FRAME_READER -- requirements
Module: fft_frame_reader

---
 rtl/fft_frame_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_fft_frame_reader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_reader.sv
// fft_frame_reader: captures one FFT frame of complex bins as |X|^2 magnitudes,
// tracks the peak bin while capturing, and holds the frame for a host to read.
//
// Ports:
//   sclk, rst          clock (rising edge) and synchronous active-high reset
//   in_valid/sop/eop   FFT output sample strobes (sop/eop qualified by in_valid)
//   in_re, in_im       signed 14-bit bin value
//   frame_ack          host releases the held frame
//   rd_addr -> rd_mag  magnitude read port, 1-cycle latency, usable in any state
//   frame_rdy          a complete frame is held
//   peak_bin/peak_mag  largest-magnitude bin of the held frame (lowest index on ties)
//   frame_err          one-cycle pulse when a frame is discarded as malformed
//   drop_cnt           saturating count of sop samples seen while holding
//
// Build option: define FFT_READER_DC_SKIP_EN to exclude bin 0 from the peak search.

module fft_frame_reader #(
    parameter int unsigned FFT_LEN = 64,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic signed [13:0]       in_re,
    input  logic signed [13:0]       in_im,
    input  logic                     frame_ack,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [27:0]              rd_mag,
    output logic                     frame_rdy,
    output logic [ADDR_W-1:0]        peak_bin,
    output logic [27:0]              peak_mag,
    output logic                     frame_err,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned MAG_W = 28;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IN_W  = 14;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_LEN - 1);

`ifdef FFT_READER_DC_SKIP_EN
    localparam logic [ADDR_W-1:0] SEED_BIN = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] SEED_BIN = ADDR_W'(0);
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_bin;
    logic [ADDR_W-1:0]  w_bin_nxt;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic               w_err;
    logic               w_to_hold;
    logic               w_drop;

    logic               r_frame_rdy;
    logic [ADDR_W-1:0]  r_peak_bin;
    logic [MAG_W-1:0]   r_peak_mag;
    logic               r_frame_err;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [ADDR_W-1:0]  r_run_bin;
    logic [MAG_W-1:0]   r_run_mag;
    logic [MAG_W-1:0]   r_rd_mag;
    logic [MAG_W-1:0]   r_mem [FFT_LEN];

    // |X|^2: each square is at most 2^26, so the sum fits 28 bits unsigned
    logic signed [MAG_W-1:0] w_re_ext;
    logic signed [MAG_W-1:0] w_im_ext;
    logic signed [MAG_W-1:0] w_re_sq;
    logic signed [MAG_W-1:0] w_im_sq;
    logic [MAG_W-1:0]        w_mag;

    assign w_re_ext = {{(MAG_W-IN_W){in_re[IN_W-1]}}, in_re};
    assign w_im_ext = {{(MAG_W-IN_W){in_im[IN_W-1]}}, in_im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_mag    = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    // Strict greater-than keeps the earlier (lower) bin on ties
    logic w_gt;
    assign w_gt = (w_mag > r_run_mag);

    // State register
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, bin counter and write/error/drop strobes
    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_bin;
        w_err       = 1'b0;
        w_to_hold   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && in_sop) begin
                    // sop and eop together is a one-bin frame: always malformed here
                    if (in_eop) begin
                        w_err = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_addr   = '0;
                        w_bin_nxt   = ADDR_W'(1);
                        w_state_nxt = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        // New frame started early: flag it and restart at bin 0
                        w_err = 1'b1;
                        if (in_eop) begin
                            w_bin_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_wr_en   = 1'b1;
                            w_wr_addr = '0;
                            w_bin_nxt = ADDR_W'(1);
                        end
                    end else if (r_bin == LAST_BIN) begin
                        w_bin_nxt = '0;
                        if (in_eop) begin
                            w_wr_en     = 1'b1;
                            w_to_hold   = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (in_eop) begin
                        w_err       = 1'b1;
                        w_bin_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_bin_nxt = r_bin + ADDR_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                w_drop = in_valid && in_sop;
                if (frame_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_bin_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bin counter, peak tracker, status outputs
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_bin       <= '0;
            r_frame_rdy <= 1'b0;
            r_peak_bin  <= '0;
            r_peak_mag  <= '0;
            r_frame_err <= 1'b0;
            r_drop_cnt  <= '0;
            r_run_bin   <= '0;
            r_run_mag   <= '0;
        end else begin
            r_bin       <= w_bin_nxt;
            r_frame_rdy <= (w_state_nxt == ST_HOLD);
            r_frame_err <= w_err;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            // Seed at the first bin that takes part in the search, then track
            if (w_wr_en) begin
                if (w_wr_addr == SEED_BIN) begin
                    r_run_mag <= w_mag;
                    r_run_bin <= SEED_BIN;
                end else if ((w_wr_addr > SEED_BIN) && w_gt) begin
                    r_run_mag <= w_mag;
                    r_run_bin <= w_wr_addr;
                end
            end
            // The final bin is folded in on the way into HOLD
            if (w_to_hold) begin
                r_peak_mag <= w_gt ? w_mag : r_run_mag;
                r_peak_bin <= w_gt ? r_bin : r_run_bin;
            end
        end
    end

    // Magnitude buffer and read port; contents deliberately survive reset
    always_ff @(posedge sclk) begin
        if (w_wr_en && !rst) begin
            r_mem[w_wr_addr] <= w_mag;
        end
        r_rd_mag <= r_mem[rd_addr];
    end

    assign rd_mag    = r_rd_mag;
    assign frame_rdy = r_frame_rdy;
    assign peak_bin  = r_peak_bin;
    assign peak_mag  = r_peak_mag;
    assign frame_err = r_frame_err;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fft_frame_reader.sv
// Testbench for fft_frame_reader (FFT_LEN=64). Stimulus pushes expected events
// into queues; a negedge monitor pops and compares when the DUT presents them.
// Build option FFT_READER_DC_SKIP_EN changes the expected peak of the DC frame.

module tb_fft_frame_reader;

    localparam int unsigned FFT_LEN = 64;
    localparam int unsigned ADDR_W  = 6;

    logic                     sclk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_sop = 1'b0;
    logic                     in_eop = 1'b0;
    logic signed [13:0]       in_re = '0;
    logic signed [13:0]       in_im = '0;
    logic                     frame_ack = 1'b0;
    logic [ADDR_W-1:0]        rd_addr = '0;
    logic [27:0]              rd_mag;
    logic                     frame_rdy;
    logic [ADDR_W-1:0]        peak_bin;
    logic [27:0]              peak_mag;
    logic                     frame_err;
    logic [7:0]               drop_cnt;

    fft_frame_reader #(.FFT_LEN(FFT_LEN), .ADDR_W(ADDR_W)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_re     (in_re),
        .in_im     (in_im),
        .frame_ack (frame_ack),
        .rd_addr   (rd_addr),
        .rd_mag    (rd_mag),
        .frame_rdy (frame_rdy),
        .peak_bin  (peak_bin),
        .peak_mag  (peak_mag),
        .frame_err (frame_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 sclk = ~sclk;

    typedef struct { int bin; int mag; } peak_t;
    typedef struct { int rdy; int drop; int bin; int mag; bit chk_peak; } stat_t;

    int    n_checks = 0;
    int    n_errors = 0;
    peak_t q_peak[$];
    stat_t q_stat[$];
    int    q_rd[$];
    int    q_err[$];
    logic  rd_req = 1'b0;
    logic  stat_req = 1'b0;
    int    fr_re[FFT_LEN];
    int    fr_im[FFT_LEN];
    int    dc_bin;
    int    dc_mag;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Every task starts and ends 1 time unit after a rising edge
    task automatic drive(input bit sop, input bit eop, input int re, input int im);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_re    = 14'(re);
        in_im    = 14'(im);
        @(posedge sclk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk); #1;
        end
    endtask

    task automatic fill(input int re, input int im);
        for (int i = 0; i < int'(FFT_LEN); i++) begin
            fr_re[i] = re;
            fr_im[i] = im;
        end
    endtask

    task automatic send_frame(input int n, input bit eop_last);
        for (int i = 0; i < n; i++) begin
            drive(i == 0, eop_last && (i == n - 1), fr_re[i], fr_im[i]);
        end
    endtask

    task automatic read_check(input int addr, input int exp);
        rd_addr = ADDR_W'(addr);
        rd_req  = 1'b1;
        q_rd.push_back(exp);
        @(posedge sclk); #1;
        rd_req  = 1'b0;
    endtask

    task automatic status_check(input int rdy, input int drop, input int bin, input int mag, input bit chk_peak);
        stat_t s;
        s.rdy = rdy; s.drop = drop; s.bin = bin; s.mag = mag; s.chk_peak = chk_peak;
        q_stat.push_back(s);
        stat_req = 1'b1;
        @(posedge sclk); #1;
        stat_req = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(posedge sclk); #1;
        frame_ack = 1'b0;
    endtask

    task automatic expect_peak(input int bin, input int mag);
        peak_t p;
        p.bin = bin; p.mag = mag;
        q_peak.push_back(p);
    endtask

    task automatic expect_err();
        q_err.push_back(1);
    endtask

    // Monitor: compares DUT events against the scoreboard queues
    initial begin
        bit    rd_pend;
        bit    prev_rdy;
        peak_t p;
        stat_t s;
        int    e;
        rd_pend  = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge sclk);
            if (rd_pend && q_rd.size() > 0) begin
                e = q_rd.pop_front();
                check("rd_mag", rd_mag, e);
            end
            rd_pend = rd_req;
            if (stat_req && q_stat.size() > 0) begin
                s = q_stat.pop_front();
                check("frame_rdy", frame_rdy, s.rdy);
                check("drop_cnt", drop_cnt, s.drop);
                if (s.chk_peak) begin
                    check("stat_peak_bin", peak_bin, s.bin);
                    check("stat_peak_mag", peak_mag, s.mag);
                end
            end
            if (frame_err === 1'b1) begin
                e = (q_err.size() > 0) ? q_err.pop_front() : 0;
                check("frame_err", frame_err, e);
            end
            if (!prev_rdy && frame_rdy === 1'b1) begin
                if (q_peak.size() > 0) begin
                    p = q_peak.pop_front();
                    check("peak_bin", peak_bin, p.bin);
                    check("peak_mag", peak_mag, p.mag);
                end else begin
                    check("frame_rdy_unexpected", frame_rdy, 0);
                end
            end
            prev_rdy = (frame_rdy === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        status_check(0, 0, 0, 0, 1);

        // Single peak at bin 17: 100^2 + 50^2 = 12500
        fill(0, 0);
        fr_re[17] = 100; fr_im[17] = -50;
        expect_peak(17, 12500);
        send_frame(64, 1);
        status_check(1, 0, 17, 12500, 1);
        read_check(17, 12500);
        read_check(0, 0);
        read_check(63, 0);
        ack();
        status_check(0, 0, 17, 12500, 1);

        // Tie between bins 5 and 9: lowest index wins, 300^2+400^2 = 250000
        fill(1, 1);
        fr_re[5] = 300; fr_im[5] = 400;
        fr_re[9] = 300; fr_im[9] = 400;
        expect_peak(5, 250000);
        send_frame(64, 1);
        status_check(1, 0, 5, 250000, 1);
        read_check(9, 250000);
        read_check(10, 2);
        ack();

        // Early eop at bin 40
        fill(7, 0);
        expect_err();
        send_frame(41, 1);
        status_check(0, 0, 5, 250000, 1);
        drive(0, 0, 3, 3);
        idle(2);

        // sop and eop on one sample
        expect_err();
        drive(1, 1, 9, 9);
        status_check(0, 0, 5, 250000, 1);

        // Last bin without eop
        expect_err();
        send_frame(64, 0);
        status_check(0, 0, 5, 250000, 1);

        // sop mid-capture restarts at bin 0; old bin 3 value must not survive
        fill(0, 0);
        fr_re[3] = 200;
        send_frame(10, 0);
        fill(0, 0);
        fr_im[20] = -9;
        expect_err();
        expect_peak(20, 81);
        send_frame(64, 1);
        status_check(1, 0, 20, 81, 1);
        read_check(3, 0);
        ack();

        // Held frame, three dropped frames, then release and recapture
        fill(0, 0);
        fr_re[42] = 50;
        expect_peak(42, 2500);
        send_frame(64, 1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                drive(i == 0, i == 7, 1000, 0);
            end
        end
        status_check(1, 3, 42, 2500, 1);
        read_check(0, 0);
        read_check(42, 2500);
        ack();
        status_check(0, 3, 42, 2500, 1);
        fill(3, 4);
        fr_re[60] = -120; fr_im[60] = 50;
        expect_peak(60, 16900);
        send_frame(64, 1);
        status_check(1, 3, 60, 16900, 1);
        read_check(59, 25);

        // frame_ack coinciding with sop: released, and the sample is dropped
        frame_ack = 1'b1;
        drive(1, 0, 11, 0);
        frame_ack = 1'b0;
        status_check(0, 4, 60, 16900, 1);
        drive(0, 1, 5, 5);
        idle(1);
        status_check(0, 4, 60, 16900, 1);

        // Reset at bin 30 of a capture, then a clean frame
        fill(0, 0);
        fr_re[10] = 500;
        send_frame(30, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        status_check(0, 0, 0, 0, 1);
        fill(2, -3);
        fr_re[3] = -7; fr_im[3] = 7;
        expect_peak(3, 98);
        send_frame(64, 1);
        status_check(1, 0, 3, 98, 1);
        read_check(3, 98);
        read_check(10, 13);
        ack();

        // Full-scale DC bin: (-8192)^2 * 2 = 2^27
        fill(1, 0);
        fr_re[0] = -8192; fr_im[0] = -8192;
`ifdef FFT_READER_DC_SKIP_EN
        dc_bin = 1; dc_mag = 1;
`else
        dc_bin = 0; dc_mag = 134217728;
`endif
        expect_peak(dc_bin, dc_mag);
        send_frame(64, 1);
        status_check(1, 0, dc_bin, dc_mag, 1);
        read_check(0, 134217728);
        read_check(1, 1);

        // drop_cnt saturates at 255
        for (int i = 0; i < 260; i++) begin
            drive(1, 0, 0, 0);
        end
        status_check(1, 255, dc_bin, dc_mag, 1);
        ack();
        status_check(0, 255, dc_bin, dc_mag, 1);

        // Let the monitor drain; anything left over was never seen
        for (int t = 0; t < 100; t++) begin
            if (q_rd.size() == 0 && q_stat.size() == 0 && q_err.size() == 0 && q_peak.size() == 0) break;
            idle(1);
        end
        idle(2);
        check("pending_rd", q_rd.size(), 0);
        check("pending_stat", q_stat.size(), 0);
        check("missed_frame_err", q_err.size(), 0);
        check("missed_frame_rdy", q_peak.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
